// File: rtl/ant_pkg.sv
// Shared constants, types, arctan table and ant bitmap for the sprite rotator.
// Latency: n/a (package).
// Backpressure: n/a (package).
package ant_pkg;

    localparam int SIZE         = 57;
    localparam int CENTER       = (SIZE - 1) / 2;
    localparam int ANGLE_W      = 13;
    localparam int CORDIC_ITERS = 12;
    localparam int ACC_W        = 18;
    localparam int FRAC_W       = 10;
    localparam int IDX_W        = 6;
    localparam int CNT_W        = 6;
    localparam int COMP_W       = 10;

    typedef logic signed [ANGLE_W-1:0] angleT;
    typedef logic [SIZE-1:0]           rowT;
    typedef logic [SIZE-1:0][SIZE-1:0] bitmapT;

    localparam angleT CORDIC_K = 13'sd622;
    localparam angleT HALF_PI  = 13'sd1608;
    localparam angleT ONE      = 13'sd1024;

    // Pixel-centre origin plus half a pixel, so a shift gives nearest-neighbour rounding
    localparam logic signed [ACC_W-1:0] ORIGIN_OFS =
        ACC_W'((CENTER << FRAC_W) + (1 << (FRAC_W - 1)));

    localparam logic [IDX_W-1:0] SIZE_IDX  = IDX_W'(SIZE);
    localparam logic [IDX_W-1:0] LAST_ROW  = IDX_W'(SIZE - 1);
    localparam logic [CNT_W-1:0] LAST_COL  = CNT_W'(SIZE - 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(CORDIC_ITERS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CORDIC,
        ST_SETUP,
        ST_PIXEL,
        ST_EMIT,
        ST_FINISH
    } stateT;

    // atan(2^-i) in Q2.10 radians
    function automatic angleT atanEntry(input logic [3:0] i);
        case (i)
            4'd0:    return 13'sd804;
            4'd1:    return 13'sd475;
            4'd2:    return 13'sd251;
            4'd3:    return 13'sd127;
            4'd4:    return 13'sd64;
            4'd5:    return 13'sd32;
            4'd6:    return 13'sd16;
            4'd7:    return 13'sd8;
            4'd8:    return 13'sd4;
            4'd9:    return 13'sd2;
            4'd10:   return 13'sd1;
            4'd11:   return 13'sd1;
            default: return 13'sd0;
        endcase
    endfunction

    // Ant facing up: head, thorax, abdomen, antennae, three leg pairs, and a
    // cleared spot on the left of the abdomen so the sprite has no mirror symmetry.
    function automatic logic antPixel(input int r, input int c);
        int dx;
        int adx;
        logic p;
        dx  = c - CENTER;
        adx = (dx < 0) ? -dx : dx;
        p   = 1'b0;
        if ((r - 8) * (r - 8) + dx * dx <= 25) p = 1'b1;
        if (4 * dx * dx + (r - 20) * (r - 20) <= 64) p = 1'b1;
        if (169 * dx * dx + 81 * (r - 40) * (r - 40) <= 13689) p = 1'b1;
        if (r <= 3 && adx == 7 - r) p = 1'b1;
        if ((r == 15 || r == 20 || r == 25) && adx >= 4 && adx <= 16) p = 1'b1;
        if (adx == 16 && ((r >= 9 && r <= 15) || (r >= 25 && r <= 31))) p = 1'b1;
        if ((r - 38) * (r - 38) + (c - 22) * (c - 22) <= 4) p = 1'b0;
        return p;
    endfunction

    function automatic bitmapT buildBitmap();
        bitmapT bm;
        for (int r = 0; r < SIZE; r++) begin
            for (int c = 0; c < SIZE; c++) begin
                bm[r][c] = antPixel(r, c);
            end
        end
        return bm;
    endfunction

endpackage

// File: rtl/ant_sprite_rom.sv
// Ant bitmap ROM: one SIZE-bit row per read, bit c = column c; rows >= SIZE read as zero.
// Latency: combinational.
// Backpressure: none.
module ant_sprite_rom
    import ant_pkg::*;
(
    input  logic [IDX_W-1:0] v,
    output rowT              rowBits
);

    localparam bitmapT BITMAP = buildBitmap();

    // Table lookup with out-of-range rows forced blank
    always_comb begin
        rowBits = '0;
        if (v < SIZE_IDX) rowBits = BITMAP[v];
    end

endmodule

// File: rtl/ant_sprite_rotator.sv
// Rotates the ant bitmap by the heading once per frame and streams rows; also emits heading step.
// Latency: start -> done in CORDIC_ITERS + 2 + SIZE*(SIZE+1) cycles; one row strobe per SIZE+1 cycles.
// Backpressure: none; consumer must accept every row_valid strobe, starts while busy are dropped.
module ant_sprite_rotator
    import ant_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    input  logic [ANGLE_W-1:0] angle,
    output logic               busy,
    output logic               row_valid,
    output logic [IDX_W-1:0]   row_idx,
    output logic [SIZE-1:0]    row_data,
    output logic               done,
    output logic [COMP_W-1:0]  xcomp,
    output logic [COMP_W-1:0]  ycomp
);

    localparam int CW = ANGLE_W + 1;
    typedef logic signed [CW-1:0]    cordT;
    typedef logic signed [ACC_W-1:0] accT;

    localparam cordT UNIT = cordT'(ONE);

    stateT            state, stateNext;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] rowCnt;

    cordT  cx, cy, cz, cxNext, cyNext, czNext, xShift, yShift, z0;
    logic  quadPos, quadNeg, prePos, preNeg;
    angleT angleS, cosC, sinC, cosV, sinV;

    accT sx, sy, rowSx, rowSy, setupSx, setupSy, cosE, sinE, tu, tv, uFull, vFull;
    logic [IDX_W-1:0] uIdx, vIdx, romV;
    logic             uOk, vOk, pix;
    rowT              romRow, rowBuf, rowMerged, rowDataQ;

    logic signed [COMP_W-1:0] xcompQ, ycompQ;

    function automatic cordT extCord(input angleT v);
        return {v[ANGLE_W-1], v};
    endfunction

    function automatic accT extAcc(input angleT v);
        return {{(ACC_W - ANGLE_W){v[ANGLE_W-1]}}, v};
    endfunction

    // 28*v as 16v + 8v + 4v
    function automatic accT times28(input angleT v);
        accT e;
        e = extAcc(v);
        return (e <<< 4) + (e <<< 3) + (e <<< 2);
    endfunction

    function automatic angleT satUnit(input cordT v);
        if (v > UNIT)       return ONE;
        else if (v < -UNIT) return -ONE;
        else                return v[ANGLE_W-1:0];
    endfunction

    // Fold angles beyond +-pi/2 into CORDIC convergence range
    always_comb begin
        angleS = $signed(angle);
        prePos = angleS > HALF_PI;
        preNeg = angleS < -HALF_PI;
        z0     = extCord(angleS);
        if (prePos)      z0 = extCord(angleS) - extCord(HALF_PI);
        else if (preNeg) z0 = extCord(angleS) + extCord(HALF_PI);
    end

    // One CORDIC micro-rotation, direction from the residual angle sign
    always_comb begin
        xShift = cx >>> cnt[3:0];
        yShift = cy >>> cnt[3:0];
        if (!cz[CW-1]) begin
            cxNext = cx - yShift;
            cyNext = cy + xShift;
            czNext = cz - extCord(atanEntry(cnt[3:0]));
        end else begin
            cxNext = cx + yShift;
            cyNext = cy - xShift;
            czNext = cz + extCord(atanEntry(cnt[3:0]));
        end
    end

    // Saturated sin/cos with the pre-rotation quadrant undone
    always_comb begin
        cosC = satUnit(cx);
        sinC = satUnit(cy);
        cosV = cosC;
        sinV = sinC;
        if (quadPos) begin
            cosV = -sinC;
            sinV = cosC;
        end else if (quadNeg) begin
            cosV = sinC;
            sinV = -cosC;
        end
        cosE    = extAcc(cosV);
        sinE    = extAcc(sinV);
        setupSx = -times28(cosV) - times28(sinV);
        setupSy = times28(sinV) - times28(cosV);
    end

    // Nearest-neighbour source pixel; anything outside the bitmap (incl. negative) reads 0
    always_comb begin
        tu    = sx + ORIGIN_OFS;
        tv    = sy + ORIGIN_OFS;
        uFull = tu >>> FRAC_W;
        vFull = tv >>> FRAC_W;
        uIdx  = uFull[IDX_W-1:0];
        vIdx  = vFull[IDX_W-1:0];
        uOk   = (uFull[ACC_W-1:IDX_W] == '0) && (uIdx < SIZE_IDX);
        vOk   = (vFull[ACC_W-1:IDX_W] == '0) && (vIdx < SIZE_IDX);
        romV  = vOk ? vIdx : '0;
        pix   = uOk && vOk && romRow[uIdx];
        rowMerged      = rowBuf;
        rowMerged[cnt] = pix;
    end

    ant_sprite_rom uRom (
        .v       (romV),
        .rowBits (romRow)
    );

    // FSM state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= ST_IDLE;
        else     state <= stateNext;
    end

    // FSM next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE:   if (start) stateNext = ST_CORDIC;
            ST_CORDIC: if (cnt == LAST_ITER) stateNext = ST_SETUP;
            ST_SETUP:  stateNext = ST_PIXEL;
            ST_PIXEL:  if (cnt == LAST_COL) stateNext = ST_EMIT;
            ST_EMIT:   stateNext = (rowCnt == LAST_ROW) ? ST_FINISH : ST_PIXEL;
            ST_FINISH: stateNext = ST_IDLE;
            default:   stateNext = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy      = (state == ST_CORDIC) || (state == ST_SETUP) ||
                    (state == ST_PIXEL)  || (state == ST_EMIT);
        row_valid = (state == ST_EMIT);
        done      = (state == ST_FINISH);
    end

    // Datapath: CORDIC iterator, coordinate accumulators and row assembly
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt      <= '0;
            rowCnt   <= '0;
            cx       <= '0;
            cy       <= '0;
            cz       <= '0;
            quadPos  <= 1'b0;
            quadNeg  <= 1'b0;
            sx       <= '0;
            sy       <= '0;
            rowSx    <= '0;
            rowSy    <= '0;
            rowBuf   <= '0;
            rowDataQ <= '0;
            xcompQ   <= '0;
            ycompQ   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cx      <= extCord(CORDIC_K);
                        cy      <= '0;
                        cz      <= z0;
                        quadPos <= prePos;
                        quadNeg <= preNeg;
                        cnt     <= '0;
                        rowCnt  <= '0;
                    end
                end
                ST_CORDIC: begin
                    cx  <= cxNext;
                    cy  <= cyNext;
                    cz  <= czNext;
                    cnt <= (cnt == LAST_ITER) ? '0 : cnt + 1'b1;
                end
                ST_SETUP: begin
                    rowSx  <= setupSx;
                    rowSy  <= setupSy;
                    sx     <= setupSx;
                    sy     <= setupSy;
                    xcompQ <= sinV[ANGLE_W-1:ANGLE_W-COMP_W];
                    ycompQ <= -$signed(cosV[ANGLE_W-1:ANGLE_W-COMP_W]);
                    cnt    <= '0;
                end
                ST_PIXEL: begin
                    rowBuf <= rowMerged;
                    sx     <= sx + cosE;
                    sy     <= sy - sinE;
                    if (cnt == LAST_COL) begin
                        rowDataQ <= rowMerged;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_EMIT: begin
                    rowSx  <= rowSx + sinE;
                    rowSy  <= rowSy + cosE;
                    sx     <= rowSx + sinE;
                    sy     <= rowSy + cosE;
                    rowCnt <= rowCnt + 1'b1;
                end
                ST_FINISH: begin
                    rowCnt <= '0;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    assign row_idx  = rowCnt;
    assign row_data = rowDataQ;
    assign xcomp    = xcompQ;
    assign ycomp    = ycompQ;

endmodule

// File: tb/tb_ant_sprite_rotator.sv
// Directed bench for ant_sprite_rotator: rotations at 0, +-90 and 180 degrees, start-while-busy, reset abort.
// Latency: checks start -> done of 3320 cycles.
// Backpressure: none; every row strobe is captured at the falling edge.
module tb_ant_sprite_rotator;

    localparam int N = 57;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic [12:0] angle;
    logic        busy;
    logic        row_valid;
    logic [5:0]  row_idx;
    logic [56:0] row_data;
    logic        done;
    logic [9:0]  xcomp;
    logic [9:0]  ycomp;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int startCyc = 0;

    int          strobes  = 0;
    int          doneCnt  = 0;
    int          doneCyc  = 0;
    int          orderErr = 0;
    logic [5:0]  idxExpect = '0;
    logic [56:0] cap [N];

    ant_sprite_rotator dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .angle     (angle),
        .busy      (busy),
        .row_valid (row_valid),
        .row_idx   (row_idx),
        .row_data  (row_data),
        .done      (done),
        .xcomp     (xcomp),
        .ycomp     (ycomp)
    );

    // Pixel clock
    always #5 CLK = ~CLK;

    // Cycle counter
    always @(posedge CLK) cyc <= cyc + 1;

    // Row/done monitor sampled away from the active edge
    always @(negedge CLK) begin
        if (RST || (start && !busy)) idxExpect <= '0;
        if (row_valid) begin
            strobes <= strobes + 1;
            if (row_idx != idxExpect) orderErr <= orderErr + 1;
            idxExpect <= row_idx + 6'd1;
            if (row_idx < 6'd57) cap[row_idx] <= row_data;
        end
        if (done) begin
            doneCnt <= doneCnt + 1;
            doneCyc <= cyc;
        end
    end

    // Reference ant sprite, drawn from its geometric description
    function automatic bit refBit(input int r, input int c);
        int x;
        int ax;
        bit on;
        x  = c - 28;
        ax = (x < 0) ? -x : x;
        on = ((r - 8) * (r - 8) + x * x <= 25)
          || (4 * x * x + (r - 20) * (r - 20) <= 64)
          || (169 * x * x + 81 * (r - 40) * (r - 40) <= 13689)
          || (r <= 3 && ax == 7 - r)
          || ((r == 15 || r == 20 || r == 25) && ax >= 4 && ax <= 16)
          || (ax == 16 && ((r >= 9 && r <= 15) || (r >= 25 && r <= 31)));
        if ((r - 38) * (r - 38) + (c - 22) * (c - 22) <= 4) on = 1'b0;
        return on;
    endfunction

    // Expected destination row for a rotation mode: 0 = 0deg, 1 = +90, 2 = -90, 3 = 180
    function automatic logic [56:0] expRow(input int mode, input int r);
        logic [56:0] e;
        for (int c = 0; c < N; c++) begin
            case (mode)
                0:       e[c] = refBit(r, c);
                1:       e[c] = refBit(56 - c, r);
                2:       e[c] = refBit(c, 56 - r);
                default: e[c] = refBit(56 - r, 56 - c);
            endcase
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkNear(input string tag, input int obs, input int exp);
        checks++;
        assert (((obs >= exp - 1) && (obs <= exp + 1)) === 1'b1) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d(+-1)", tag, obs, exp);
        end
    endtask

    task automatic pulseStart(input logic [12:0] a);
        @(posedge CLK); #1;
        angle    = a;
        start    = 1'b1;
        startCyc = cyc;
        @(posedge CLK); #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input int base);
        for (int i = 0; i < 4000; i++) begin
            if (doneCnt != base) break;
            @(posedge CLK);
        end
        repeat (2) @(posedge CLK);
        #1;
    endtask

    task automatic checkFrame(input string tag, input int mode, input int expX, input int expY,
                              input int dBase, input int sBase, input int oBase);
        check({tag, "_done_count"}, 64'(doneCnt - dBase), 64'd1);
        check({tag, "_latency"}, 64'(doneCyc - startCyc), 64'd3320);
        check({tag, "_strobes"}, 64'(strobes - sBase), 64'd57);
        check({tag, "_row_order"}, 64'(orderErr - oBase), 64'd0);
        check({tag, "_busy_idle"}, 64'(busy), 64'd0);
        checkNear({tag, "_xcomp"}, int'($signed(xcomp)), expX);
        checkNear({tag, "_ycomp"}, int'($signed(ycomp)), expY);
        for (int r = 0; r < N; r++) begin
            check($sformatf("%s_row%0d", tag, r), 64'(cap[r]), 64'(expRow(mode, r)));
        end
    endtask

    task automatic runFrame(input string tag, input logic [12:0] a, input int mode,
                            input int expX, input int expY);
        int dB, sB, oB;
        dB = doneCnt;
        sB = strobes;
        oB = orderErr;
        pulseStart(a);
        waitDone(dB);
        checkFrame(tag, mode, expX, expY, dB, sB, oB);
    endtask

    initial begin
        int dB, sB, oB, firstStart;
        RST   = 1'b1;
        start = 1'b0;
        angle = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_row_valid", 64'(row_valid), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_row_idx", 64'(row_idx), 64'd0);
        check("reset_row_data", 64'(row_data), 64'd0);
        check("reset_xcomp", 64'(xcomp), 64'd0);
        check("reset_ycomp", 64'(ycomp), 64'd0);
        @(posedge CLK); #1;
        RST = 1'b0;

        // Rotations: identity, +90, -90 and 180 (pre-rotation path)
        runFrame("a0", 13'd0, 0, 0, -128);
        runFrame("p90", 13'sd1608, 1, 128, 0);
        runFrame("m90", -13'sd1608, 2, -128, 0);
        runFrame("a180", 13'sd3216, 3, 0, 128);

        // Second start while busy, with a different angle, must be ignored
        dB = doneCnt;
        sB = strobes;
        oB = orderErr;
        pulseStart(13'd0);
        firstStart = startCyc;
        check("busy_after_start", 64'(busy), 64'd1);
        repeat (99) @(posedge CLK);
        #1;
        angle = 13'sd1608;
        start = 1'b1;
        check("busy_at_restart", 64'(busy), 64'd1);
        @(posedge CLK); #1;
        start = 1'b0;
        waitDone(dB);
        repeat (200) @(posedge CLK);
        #1;
        startCyc = firstStart;
        checkFrame("restart", 0, 0, -128, dB, sB, oB);

        // Reset mid-frame aborts with no done; a fresh start then completes
        dB = doneCnt;
        pulseStart(13'd0);
        repeat (999) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(negedge CLK);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_row_valid", 64'(row_valid), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_row_idx", 64'(row_idx), 64'd0);
        check("abort_row_data", 64'(row_data), 64'd0);
        check("abort_xcomp", 64'(xcomp), 64'd0);
        check("abort_ycomp", 64'(ycomp), 64'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        repeat (2600) @(posedge CLK);
        #1;
        check("abort_no_done", 64'(doneCnt - dB), 64'd0);
        check("abort_idle", 64'(busy), 64'd0);
        runFrame("after_abort", 13'd0, 0, 0, -128);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
